vga_sync_decoder: RTL

- Receive-side counterpart of the 640x480@72Hz sync generator.
- Consumes hsync/vsync in the px_clk domain, measures line and frame timing, and checks it against the expected mode.
- Declares lock after consecutive matching frames, then regenerates pixel coordinates and a data-enable for downstream overlay, capture or self-check logic.

---
 rtl/vga_sync_decoder.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// +--------------------------------------------------------------------------+
// | Module   : vga_sync_decoder                                              |
// | Purpose  : Receive-side timing decoder for the 640x480@72Hz sync mode.   |
// |            Measures line/frame timing from hsync/vsync, checks it       |
// |            against the expected mode, declares lock after LOCK_FRAMES   |
// |            matching frames and regenerates x/y coordinates plus a       |
// |            data-enable for downstream logic.                            |
// | Ports    : px_clk, reset (sync, active-high)                             |
// |            hsync_in, vsync_in       sync inputs in the px_clk domain     |
// |            x_px, y_px, de_out       recovered coordinates / enable       |
// |            frame_start              pulse on first active pixel          |
// |            locked, timing_err       lock status / sticky mismatch        |
// |            h_total_meas, v_total_meas  last measured line/frame length  |
// | Options  : define VGA_SYNC_DECODER_WATCHDOG_EN to drop lock when no      |
// |            hsync edge arrives within two lines, or no vsync edge within |
// |            two frames.                                                  |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module vga_sync_decoder #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 24,
  parameter int H_PULSE         = 40,
  parameter int H_BP            = 128,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 9,
  parameter int V_PULSE         = 3,
  parameter int V_BP            = 28,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic       px_clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] x_px,
  output logic [9:0] y_px,
  output logic       de_out,
  output logic       frame_start,
  output logic       locked,
  output logic [9:0] h_total_meas,
  output logic [9:0] v_total_meas,
  output logic       timing_err
);

  localparam logic [9:0] c_H_TOTAL = 10'(H_ACTIVE + H_FP + H_PULSE + H_BP);
  localparam logic [9:0] c_V_TOTAL = 10'(V_ACTIVE + V_FP + V_PULSE + V_BP);
  localparam logic [9:0] c_H_PULSE = 10'(H_PULSE);
  localparam logic [9:0] c_V_PULSE = 10'(V_PULSE);
  localparam logic [9:0] c_H_START = 10'(H_PULSE + H_BP);
  localparam logic [9:0] c_H_END   = 10'(H_PULSE + H_BP + H_ACTIVE);
  localparam logic [9:0] c_V_START = 10'(V_PULSE + V_BP);
  localparam logic [9:0] c_V_END   = 10'(V_PULSE + V_BP + V_ACTIVE);
  localparam logic [9:0] c_SAT     = 10'd1023;
  localparam logic [9:0] c_ONE     = 10'd1;
  localparam logic [2:0] c_LOCK    = 3'(LOCK_FRAMES);
  localparam logic       c_POL     = (SYNC_ACTIVE_LOW != 0);

  logic       r_hs_prev, r_vs_prev;
  logic [9:0] r_p, r_q;
  logic       r_v_pend;
  logic [9:0] r_hpw_cnt, r_hpw, r_vpw_cnt, r_vpw;
  logic [9:0] r_h_total, r_v_total;
  logic       r_q_synced, r_v_valid;  // v_total_meas spans a full frame
  logic       r_armed;                // first V-edge after reset seen
  logic       r_h_bad;                // a line in this frame mismatched
  logic [2:0] r_good;
  logic       r_locked, r_err;

  logic       w_hs, w_vs, w_h_edge, w_h_fall, w_v_edge, w_v_fall;
  logic [9:0] w_p, w_p_inc, w_q, w_q_inc;
  logic       w_hline_bad, w_hpw_bad, w_frame_ok, w_de, w_wd_trip;
  logic [2:0] w_good_inc;

  // Normalise both syncs to active-high.
  assign w_hs     = hsync_in ^ c_POL;
  assign w_vs     = vsync_in ^ c_POL;
  assign w_h_edge = w_hs & ~r_hs_prev;
  assign w_h_fall = ~w_hs & r_hs_prev;
  assign w_v_edge = w_vs & ~r_vs_prev;
  assign w_v_fall = ~w_vs & r_vs_prev;

  // p is 0 in the H-edge cycle itself; r_p therefore holds the line length
  // so far, which is exactly the measurement latched at the next H-edge.
  assign w_p     = w_h_edge ? '0 : r_p;
  assign w_p_inc = (w_p == c_SAT) ? c_SAT : w_p + c_ONE;
  assign w_q_inc = (r_q == c_SAT) ? c_SAT : r_q + c_ONE;
  // The H-edge uses the pending flag as it stood before any coincident V-edge.
  assign w_q     = w_h_edge ? (r_v_pend ? '0 : w_q_inc) : r_q;

  // Per-line checks, so a single bad line anywhere in the frame is caught.
  assign w_hline_bad = w_h_edge & (r_p != c_H_TOTAL);
  assign w_hpw_bad   = w_h_fall & (r_hpw_cnt != c_H_PULSE);

  // The frame length is only compared once a complete frame was measured.
  assign w_frame_ok = ~r_h_bad & ~w_hline_bad & ~w_hpw_bad &
                      (r_h_total == c_H_TOTAL) & (r_hpw == c_H_PULSE) &
                      (~r_v_valid | (r_v_total == c_V_TOTAL)) &
                      (r_vpw == c_V_PULSE);

  assign w_good_inc = (r_good == 3'd7) ? 3'd7 : r_good + 3'd1;

  assign w_de = r_locked & (w_p >= c_H_START) & (w_p < c_H_END) &
                (w_q >= c_V_START) & (w_q < c_V_END);

`ifdef VGA_SYNC_DECODER_WATCHDOG_EN
  localparam int c_H_WD = 2 * (H_ACTIVE + H_FP + H_PULSE + H_BP);
  localparam int c_V_WD = 2 * (V_ACTIVE + V_FP + V_PULSE + V_BP);
  localparam int c_HW_W = $clog2(c_H_WD + 2);
  localparam int c_VW_W = $clog2(c_V_WD + 1);
  localparam logic [c_HW_W-1:0] c_H_WD_L  = c_HW_W'(c_H_WD);
  localparam logic [c_HW_W-1:0] c_HW_ONE  = c_HW_W'(1);
  localparam logic [c_VW_W-1:0] c_V_WD_L  = c_VW_W'(c_V_WD);
  localparam logic [c_VW_W-1:0] c_V_WD_M1 = c_VW_W'(c_V_WD - 1);
  localparam logic [c_VW_W-1:0] c_VW_ONE  = c_VW_W'(1);

  logic [c_HW_W-1:0] r_wd_h, w_wd_h;
  logic [c_VW_W-1:0] r_wd_v;

  // Separate, wider counters: the limits exceed the 10-bit p/q range.
  // Each fires once, then parks past its limit until the next edge re-arms it.
  assign w_wd_h    = w_h_edge ? '0 : r_wd_h;
  assign w_wd_trip = (w_wd_h == c_H_WD_L) |
                     (w_h_edge & ~w_v_edge & (r_wd_v == c_V_WD_M1));

  always_ff @(posedge px_clk) begin
    if (reset) begin
      r_wd_h <= '0;
      r_wd_v <= '0;
    end else begin
      r_wd_h <= (w_wd_h <= c_H_WD_L) ? w_wd_h + c_HW_ONE : w_wd_h;
      if (w_v_edge)
        r_wd_v <= '0;
      else if (w_h_edge && (r_wd_v < c_V_WD_L))
        r_wd_v <= r_wd_v + c_VW_ONE;
    end
  end
`else
  assign w_wd_trip = 1'b0;
`endif

  always_ff @(posedge px_clk) begin
    if (reset) begin
      r_hs_prev  <= 1'b0;
      r_vs_prev  <= 1'b0;
      r_p        <= '0;
      r_q        <= '0;
      r_v_pend   <= 1'b0;
      r_hpw_cnt  <= '0;
      r_hpw      <= '0;
      r_vpw_cnt  <= '0;
      r_vpw      <= '0;
      r_h_total  <= '0;
      r_v_total  <= '0;
      r_q_synced <= 1'b0;
      r_v_valid  <= 1'b0;
      r_armed    <= 1'b0;
      r_h_bad    <= 1'b0;
      r_good     <= '0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      de_out     <= 1'b0;
      x_px       <= '0;
      y_px       <= '0;
      frame_start <= 1'b0;
    end else begin
      r_hs_prev <= w_hs;
      r_vs_prev <= w_vs;
      r_p       <= w_p_inc;
      r_q       <= w_q;
      r_v_pend  <= w_v_edge | (r_v_pend & ~w_h_edge);

      if (w_h_edge)
        r_h_total <= r_p;

      if (w_h_edge)
        r_hpw_cnt <= c_ONE;
      else if (w_hs && (r_hpw_cnt != c_SAT))
        r_hpw_cnt <= r_hpw_cnt + c_ONE;
      if (w_h_fall)
        r_hpw <= r_hpw_cnt;

      // Vertical pulse width counted in H-edges seen while vsync is active.
      if (w_v_edge)
        r_vpw_cnt <= w_h_edge ? c_ONE : '0;
      else if (w_vs && w_h_edge && (r_vpw_cnt != c_SAT))
        r_vpw_cnt <= r_vpw_cnt + c_ONE;
      if (w_v_fall)
        r_vpw <= r_vpw_cnt;

      // Frame boundary resolves on the first H-edge after the V-edge.
      if (w_h_edge && r_v_pend) begin
        r_v_total  <= w_v_edge ? '0 : w_q_inc;
        r_v_valid  <= r_q_synced & ~w_v_edge;
        r_q_synced <= 1'b1;
      end

      if (w_v_edge)
        r_h_bad <= 1'b0;
      else if (w_hline_bad || w_hpw_bad)
        r_h_bad <= 1'b1;

      if (w_v_edge) begin
        r_armed <= 1'b1;
        if (r_armed) begin
          if (w_frame_ok) begin
            r_good <= w_good_inc;
            if (w_good_inc >= c_LOCK)
              r_locked <= 1'b1;
          end else begin
            r_good   <= '0;
            r_locked <= 1'b0;
            r_err    <= 1'b1;
          end
        end
      end

      if (w_wd_trip) begin
        r_good   <= '0;
        r_locked <= 1'b0;
        r_err    <= 1'b1;
      end

      de_out      <= w_de;
      frame_start <= w_de & (w_p == c_H_START) & (w_q == c_V_START);
      if (w_de) begin
        x_px <= w_p - c_H_START;
        y_px <= w_q - c_V_START;
      end
    end
  end

  assign locked       = r_locked;
  assign timing_err   = r_err;
  assign h_total_meas = r_h_total;
  assign v_total_meas = r_v_total;

endmodule

`default_nettype wire
